// File: rtl/ts_column_ctrl.sv
// Phase sequencer for one ts_column: SRAM read/write and ternary charge-domain
// compute. All column controls are registered from next-state decode.
module ts_column_ctrl #(
  parameter int N_ROWS   = 128,
  parameter int ADC_BITS = 4,
  parameter int PCH_CYC  = 2,
  parameter int WL_CYC   = 2,
  parameter int RST_CYC  = 2,
  parameter int DRV_CYC  = 4,
  parameter int ADC_CYC  = 4,
  localparam int AW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [AW-1:0]       req_addr,
  input  logic                req_wdata,
  input  logic [N_ROWS-1:0]   req_pos,
  input  logic [N_ROWS-1:0]   req_neg,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ADC_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic [N_ROWS-1:0]   VDR_SEL,
  output logic [N_ROWS-1:0]   VDR_SELB,
  output logic [N_ROWS-1:0]   VSS_SEL,
  output logic [N_ROWS-1:0]   VSS_SELB,
  output logic [N_ROWS-1:0]   VRST_SEL,
  output logic [N_ROWS-1:0]   VRST_SELB,
  output logic [N_ROWS-1:0]   WL,
  output logic                PCH,
  output logic                WR_DATA,
  output logic                WRITE,
  output logic                CSEL,
  output logic                SAEN,
  input  logic                SA_OUT,
  output logic                NF,
  output logic                NFB,
  output logic                M2A,
  output logic                M2AB,
  output logic                R2A,
  output logic                R2AB,
  input  logic [ADC_BITS-1:0] ADC_OUT
);

  localparam int CW = 16;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WLON, S_SENSE, S_CRST, S_CGAP, S_CDRV, S_CCONV, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last;
  logic                accept;

  logic [1:0]          op_q;
  logic [AW-1:0]       addr_q;
  logic                wdata_q;
  logic [N_ROWS-1:0]   pos_q, neg_q;
  logic [1:0]          op_d;
  logic [AW-1:0]       addr_d;
  logic                wdata_d;
  logic [N_ROWS-1:0]   pos_d, neg_d;
  logic [N_ROWS-1:0]   dr_rows, ss_rows;

  logic [N_ROWS-1:0]   vdr_d, vss_d, vrst_d, wl_d;
  logic                pch_d, wrd_d, write_d, csel_d, saen_d, nf_d, m2a_d, r2a_d;
  logic                rsp_valid_d, rsp_err_d;
  logic [ADC_BITS-1:0] rsp_data_d;

  function automatic logic [CW-1:0] phase_len(input state_e s);
    case (s)
      S_PRE:   return CW'(PCH_CYC - 1);
      S_WLON:  return CW'(WL_CYC - 1);
      S_CRST:  return CW'(RST_CYC - 1);
      S_CDRV:  return CW'(DRV_CYC - 1);
      S_CCONV: return CW'(ADC_CYC - 1);
      default: return '0;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && (state_q == S_IDLE);
  assign last      = (cnt_q == '0);

  // Next-cycle view of the latched request so the first phase can be decoded at accept
  assign op_d    = accept ? req_op    : op_q;
  assign addr_d  = accept ? req_addr  : addr_q;
  assign wdata_d = accept ? req_wdata : wdata_q;
  assign pos_d   = accept ? req_pos   : pos_q;
  assign neg_d   = accept ? req_neg   : neg_q;
  assign dr_rows = pos_d & ~neg_d;
  assign ss_rows = neg_d & ~pos_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      pos_q   <= req_pos;
      neg_q   <= req_neg;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_READ:    state_d = S_PRE;
            OP_WRITE:   state_d = S_WLON;
            OP_COMPUTE: state_d = S_CRST;
            default:    state_d = S_RESP;
          endcase
        end
      end
      S_PRE:   if (last) state_d = S_WLON;
      S_WLON:  if (last) state_d = (op_q == OP_READ) ? S_SENSE : S_RESP;
      S_SENSE: state_d = S_RESP;
      S_CRST:  if (last) state_d = S_CGAP;
      S_CGAP:  state_d = S_CDRV;
      S_CDRV:  if (last) state_d = S_CCONV;
      S_CCONV: if (last) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = phase_len(state_d);
    else if (!last)         cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    vdr_d   = '0;
    vss_d   = '0;
    vrst_d  = '0;
    wl_d    = '0;
    pch_d   = 1'b0;
    wrd_d   = 1'b0;
    write_d = 1'b0;
    csel_d  = 1'b0;
    saen_d  = 1'b0;
    nf_d    = 1'b0;
    m2a_d   = 1'b0;
    r2a_d   = 1'b0;
    case (state_d)
      S_PRE: pch_d = 1'b1;
      S_WLON: begin
        wl_d[addr_d] = 1'b1;
        csel_d       = 1'b1;
        if (op_d == OP_WRITE) begin
          write_d = 1'b1;
          wrd_d   = wdata_d;
        end
      end
      S_SENSE: begin
        wl_d[addr_d] = 1'b1;
        csel_d       = 1'b1;
        saen_d       = 1'b1;
      end
      S_CRST: begin
        vrst_d = '1;
        r2a_d  = 1'b1;
      end
      S_CDRV, S_CCONV: begin
        vdr_d  = dr_rows;
        vss_d  = ss_rows;
        vrst_d = ~(dr_rows | ss_rows);
        m2a_d  = (state_d == S_CDRV);
        nf_d   = (state_d == S_CCONV);
      end
      default: ;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    if (accept) begin
      rsp_data_d = '0;
      rsp_err_d  = (req_op == 2'b11);
    end
    if (state_q == S_SENSE) begin
      rsp_data_d    = '0;
      rsp_data_d[0] = SA_OUT;
    end
    if (state_q == S_CCONV && last) rsp_data_d = ADC_OUT;
  end

  // Complement rails come from the same next-state decode so they never skew
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      VDR_SEL   <= '0;
      VDR_SELB  <= '1;
      VSS_SEL   <= '0;
      VSS_SELB  <= '1;
      VRST_SEL  <= '0;
      VRST_SELB <= '1;
      WL        <= '0;
      PCH       <= 1'b0;
      WR_DATA   <= 1'b0;
      WRITE     <= 1'b0;
      CSEL      <= 1'b0;
      SAEN      <= 1'b0;
      NF        <= 1'b0;
      NFB       <= 1'b1;
      M2A       <= 1'b0;
      M2AB      <= 1'b1;
      R2A       <= 1'b0;
      R2AB      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      VDR_SEL   <= vdr_d;
      VDR_SELB  <= ~vdr_d;
      VSS_SEL   <= vss_d;
      VSS_SELB  <= ~vss_d;
      VRST_SEL  <= vrst_d;
      VRST_SELB <= ~vrst_d;
      WL        <= wl_d;
      PCH       <= pch_d;
      WR_DATA   <= wrd_d;
      WRITE     <= write_d;
      CSEL      <= csel_d;
      SAEN      <= saen_d;
      NF        <= nf_d;
      NFB       <= ~nf_d;
      M2A       <= m2a_d;
      M2AB      <= ~m2a_d;
      R2A       <= r2a_d;
      R2AB      <= ~r2a_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ts_column_ctrl.sv
// Bench for ts_column_ctrl: vector table for op latency/results plus directed
// sequences for compute phases, response hold and mid-op reset.
module tb_ts_column_ctrl;
  localparam int N  = 128;
  localparam int AB = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [6:0]    req_addr = '0;
  logic          req_wdata = 1'b0;
  logic [N-1:0]  req_pos = '0;
  logic [N-1:0]  req_neg = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AB-1:0] rsp_data;
  logic          rsp_err;
  logic [N-1:0]  VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB, WL;
  logic          PCH, WR_DATA, WRITE, CSEL, SAEN, SA_OUT;
  logic          NF, NFB, M2A, M2AB, R2A, R2AB;
  logic [AB-1:0] ADC_OUT = '0;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic [N-1:0] mem = '0;

  always #5 CLK = ~CLK;

  ts_column_ctrl dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_pos(req_pos), .req_neg(req_neg), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .VDR_SEL(VDR_SEL), .VDR_SELB(VDR_SELB), .VSS_SEL(VSS_SEL), .VSS_SELB(VSS_SELB),
    .VRST_SEL(VRST_SEL), .VRST_SELB(VRST_SELB), .WL(WL), .PCH(PCH),
    .WR_DATA(WR_DATA), .WRITE(WRITE), .CSEL(CSEL), .SAEN(SAEN), .SA_OUT(SA_OUT),
    .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB), .R2A(R2A), .R2AB(R2AB),
    .ADC_OUT(ADC_OUT)
  );

  // Behavioural bit-cell column: writes land on the active row, sense reads it back
  always @(posedge CLK) if (WRITE) mem <= WR_DATA ? (mem | WL) : (mem & ~WL);
  assign SA_OUT = SAEN & (|(WL & mem));

  wire col_any = (|VDR_SEL) | (|VSS_SEL) | (|VRST_SEL) | (|WL) | PCH | WR_DATA |
                 WRITE | CSEL | SAEN | NF | M2A | R2A;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      check("b_vdr",  VDR_SEL ^ VDR_SELB, {N{1'b1}});
      check("b_vss",  VSS_SEL ^ VSS_SELB, {N{1'b1}});
      check("b_vrst", VRST_SEL ^ VRST_SELB, {N{1'b1}});
      check("b_misc", {NF ^ NFB, M2A ^ M2AB, R2A ^ R2AB}, 3'b111);
      check("sel_excl", (VDR_SEL & VSS_SEL) | (VDR_SEL & VRST_SEL) | (VSS_SEL & VRST_SEL), '0);
      check("wl_onehot0", ($countones(WL) <= 1), 1);
      check("pch_wl", PCH & (|WL), 0);
      check("saen_sense", SAEN & ~(CSEL & (|WL)), 0);
    end
  end

  typedef struct {
    logic [1:0]   op;
    logic [6:0]   addr;
    logic         wdata;
    logic [N-1:0] pos;
    logic [N-1:0] neg;
    logic [AB-1:0] adc;
    int           lat;
    logic [AB-1:0] data;
    logic         err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [6:0] addr, input logic wd,
                              input logic [N-1:0] pos, input logic [N-1:0] neg,
                              input logic [AB-1:0] adc, input int lat,
                              input logic [AB-1:0] data, input logic err);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.pos = pos; v.neg = neg;
    v.adc = adc; v.lat = lat; v.data = data; v.err = err;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input vec_t v);
    tick();
    req_valid = 1'b1;
    req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    req_pos = v.pos; req_neg = v.neg; ADC_OUT = v.adc;
    check("ready_before", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_op = 2'b11; req_addr = ~v.addr; req_wdata = ~v.wdata;
    req_pos = v.neg; req_neg = v.pos;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    logic [N-1:0] exp_wl;
    exp_wl = '0;
    exp_wl[v.addr] = 1'b1;
    send(v);
    k = 1;
    while (!rsp_valid && k < 40) begin
      check($sformatf("v%0d_busy", idx), req_ready, 0);
      if (WL != '0) check($sformatf("v%0d_wl", idx), WL, exp_wl);
      tick();
      k++;
    end
    check($sformatf("v%0d_lat", idx), k, v.lat);
    check($sformatf("v%0d_data", idx), rsp_data, v.data);
    check($sformatf("v%0d_err", idx), rsp_err, v.err);
    check($sformatf("v%0d_idle", idx), col_any, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check($sformatf("v%0d_done", idx), {rsp_valid, req_ready}, 2'b01);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(2'b01, 7'd5,   1'b1, '0, '0, 4'h0, 3, 4'h0, 1'b0);
    vecs[1]  = mk(2'b00, 7'd5,   1'b0, '0, '0, 4'h0, 6, 4'h1, 1'b0);
    vecs[2]  = mk(2'b01, 7'd127, 1'b1, '0, '0, 4'h0, 3, 4'h0, 1'b0);
    vecs[3]  = mk(2'b00, 7'd127, 1'b0, '0, '0, 4'h0, 6, 4'h1, 1'b0);
    vecs[4]  = mk(2'b01, 7'd5,   1'b0, '0, '0, 4'h0, 3, 4'h0, 1'b0);
    vecs[5]  = mk(2'b00, 7'd5,   1'b0, '0, '0, 4'h0, 6, 4'h0, 1'b0);
    vecs[6]  = mk(2'b00, 7'd0,   1'b0, '0, '0, 4'h0, 6, 4'h0, 1'b0);
    vecs[7]  = mk(2'b10, 7'd0,   1'b0, 128'h5, 128'h6, 4'hA, 12, 4'hA, 1'b0);
    vecs[8]  = mk(2'b10, 7'd3,   1'b0, '0, '0, 4'h0, 12, 4'h0, 1'b0);
    vecs[9]  = mk(2'b10, 7'd9,   1'b1, {N{1'b1}}, '0, 4'hF, 12, 4'hF, 1'b0);
    vecs[10] = mk(2'b11, 7'd4,   1'b1, '0, '0, 4'h7, 1, 4'h0, 1'b1);
    vecs[11] = mk(2'b01, 7'd64,  1'b1, '0, '0, 4'h0, 3, 4'h0, 1'b0);

    #2 nRST = 1'b0;
    #1;
    check("rst_true", col_any, 0);
    check("rst_b", {NFB, M2AB, R2AB}, 3'b111);
    check("rst_selb", VDR_SELB & VSS_SELB & VRST_SELB, {N{1'b1}});
    check("rst_hs", {req_ready, rsp_valid, rsp_err}, 3'b100);
    check("rst_data", rsp_data, 0);
    repeat (3) @(posedge CLK);
    #3 nRST = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Compute phase walk: reset, gap, drive, convert; ADC value valid only on last conversion cycle
    begin
      logic [N-1:0] dr, ss, rs;
      dr = 128'h1; ss = 128'h2; rs = ~(dr | ss);
      send(mk(2'b10, 7'd0, 1'b0, 128'h5, 128'h6, 4'h3, 12, 4'hA, 1'b0));
      for (int k = 1; k <= 12; k++) begin
        ADC_OUT = (k == 11) ? 4'hA : 4'h3;
        if (k <= 2) begin
          check($sformatf("crst%0d_sel", k), {VDR_SEL | VSS_SEL, VRST_SEL}, {{N{1'b0}}, {N{1'b1}}});
          check($sformatf("crst%0d_ctl", k), {R2A, M2A, NF}, 3'b100);
        end else if (k == 3) begin
          check("cgap_sel", VDR_SEL | VSS_SEL | VRST_SEL, '0);
          check("cgap_ctl", {R2A, M2A, NF}, 3'b000);
        end else if (k <= 11) begin
          check($sformatf("c%0d_vdr", k), VDR_SEL, dr);
          check($sformatf("c%0d_vss", k), VSS_SEL, ss);
          check($sformatf("c%0d_vrst", k), VRST_SEL, rs);
          check($sformatf("c%0d_ctl", k), {R2A, M2A, NF}, (k <= 7) ? 3'b010 : 3'b001);
        end else begin
          check("c_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 4'hA});
          check("c_rsp_idle", col_any, 0);
        end
        check($sformatf("c%0d_vld", k), rsp_valid, (k == 12));
        if (k < 12) tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("c_done", {rsp_valid, req_ready}, 2'b01);
    end

    // Response hold under backpressure with a competing request waiting
    begin
      int k;
      send(mk(2'b00, 7'd127, 1'b0, '0, '0, 4'h0, 6, 4'h1, 1'b0));
      k = 1;
      while (!rsp_valid && k < 40) begin tick(); k++; end
      check("hold_lat", k, 6);
      req_valid = 1'b1; req_op = 2'b01; req_addr = 7'd127; req_wdata = 1'b0;
      for (int c = 0; c < 10; c++) begin
        check($sformatf("hold%0d", c), {rsp_valid, req_ready, rsp_err, rsp_data}, {3'b100, 4'h1});
        tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("hold_done", {rsp_valid, req_ready}, 2'b01);
    end

    // Asynchronous reset landing in the drive phase
    send(mk(2'b10, 7'd0, 1'b0, 128'h5, 128'h6, 4'h9, 12, 4'h9, 1'b0));
    repeat (4) tick();
    check("pre_rst_drv", M2A, 1);
    #2 nRST = 1'b0;
    #1;
    check("arst_sel", VDR_SEL | VSS_SEL | VRST_SEL | WL, '0);
    check("arst_selb", VDR_SELB & VSS_SELB & VRST_SELB, {N{1'b1}});
    check("arst_ctl", {M2A, NF, R2A, M2AB, NFB, R2AB}, 6'b000111);
    check("arst_hs", {req_ready, rsp_valid}, 2'b10);
    #2 nRST = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("arst_norsp%0d", c), {rsp_valid, req_ready}, 2'b01);
    end
    run_vec(100, mk(2'b00, 7'd127, 1'b0, '0, '0, 4'h0, 6, 4'h1, 1'b0));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
